// File: rtl/trash_cpu.sv
// trash_cpu: single-issue processor core for the trash tile.
// Fetches 16-bit instructions from an internal program store, runs one
// instruction per clock in RUN, and reports results through OUT.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (clears all state and storage)
//   prog_we    write prog_data at the load pointer (IDLE/HALTED only)
//   prog_data  instruction word to load
//   start      begin execution at pc 0 (IDLE/HALTED only)
//   out_data   last value emitted by OUT
//   out_valid  one-cycle strobe per executed OUT
//   busy       core is in RUN
//   halted     core is in HALTED
//   pc         current program counter
//
// Instruction: [15:12] op, [11:8] A, [7:4] B, [3:0] C, [7:0] imm.
// Register indices are taken modulo NUM_REGS, addresses modulo depth.
module trash_cpu #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          prog_we,
  input  logic [15:0]                   prog_data,
  input  logic                          start,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          halted,
  output logic [$clog2(PROG_DEPTH)-1:0] pc
);

  localparam int unsigned PW = $clog2(PROG_DEPTH);
  localparam int unsigned RW = $clog2(NUM_REGS);
  localparam int unsigned MW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ALU  = 4'h2,
    OP_ST   = 4'h3,
    OP_LD   = 4'h4,
    OP_JMP  = 4'h5,
    OP_JZ   = 4'h6,
    OP_OUT  = 4'h7,
    OP_HALT = 4'h8
  } op_t;

  state_t              state;
  logic [15:0]         prog [PROG_DEPTH];
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   mem  [MEM_DEPTH];
  logic [PW-1:0]       ldptr;

  // Decode of the instruction at pc
  logic [15:0]         instr;
  logic [3:0]          op;
  logic [3:0]          fn;
  logic [RW-1:0]       a_idx;
  logic [RW-1:0]       b_idx;
  logic [RW-1:0]       c_idx;
  logic [7:0]          imm;
  logic [PW-1:0]       jaddr;
  logic [MW-1:0]       maddr;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   a_val;
  logic [DATA_W-1:0]   d_val;
  logic [DATA_W-1:0]   s_val;
  logic [DATA_W-1:0]   alu_res;
  logic [PW-1:0]       pc_inc;

  // Field bits above the configured index/address widths are ignored.
  logic                unused_instr;

  always_comb begin
    instr   = prog[pc];
    op      = instr[15:12];
    fn      = instr[11:8];
    a_idx   = instr[8 +: RW];
    b_idx   = instr[4 +: RW];
    c_idx   = instr[0 +: RW];
    imm     = instr[7:0];
    jaddr   = imm[PW-1:0];
    maddr   = imm[MW-1:0];
    imm_ext = DATA_W'(imm);
    a_val   = regs[a_idx];
    d_val   = regs[b_idx];
    s_val   = regs[c_idx];
    pc_inc  = pc + 1'b1;
  end

  assign unused_instr = ^instr;

  // ALU: destination register B is the left operand, C the source.
  always_comb begin
    alu_res = d_val;
    case (fn)
      4'h0: alu_res = d_val + s_val;
      4'h1: alu_res = d_val - s_val;
      4'h2: alu_res = d_val & s_val;
      4'h3: alu_res = d_val | s_val;
      4'h4: alu_res = d_val ^ s_val;
      4'h5: alu_res = ~s_val;
      4'h6: alu_res = s_val;
      4'h7: alu_res = {d_val[DATA_W-2:0], 1'b0};
      4'h8: alu_res = {1'b0, d_val[DATA_W-1:1]};
      4'h9: alu_res = d_val + 1'b1;
      4'hA: alu_res = d_val - 1'b1;
      4'hB: alu_res = d_val * s_val;
      4'hC: alu_res = DATA_W'(d_val == s_val);
      4'hD: alu_res = DATA_W'(d_val < s_val);
      default: alu_res = d_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ldptr     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      for (int unsigned i = 0; i < PROG_DEPTH; i++) prog[i] <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)   regs[i] <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++)  mem[i]  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (prog_we) begin
            prog[ldptr] <= prog_data;
            ldptr       <= ldptr + 1'b1;
          end
          // A same-cycle load still commits at the old pointer; the
          // pointer clear below overrides its increment.
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            halted <= 1'b0;
            pc     <= '0;
            ldptr  <= '0;
          end
        end

        S_RUN: begin
          pc <= pc_inc;
          case (op)
            OP_LDI: regs[a_idx] <= imm_ext;
            OP_ALU: regs[b_idx] <= alu_res;
            OP_ST:  mem[maddr]  <= a_val;
            OP_LD:  regs[a_idx] <= mem[maddr];
            OP_JMP: pc <= jaddr;
            OP_JZ: begin
              if (a_val == '0) pc <= jaddr;
            end
            OP_OUT: begin
              out_data  <= a_val;
              out_valid <= 1'b1;
            end
            OP_HALT: begin
              pc     <= pc;
              state  <= S_HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trash_cpu.sv
// tb_trash_cpu: directed self-checking bench for trash_cpu (default sizing).
// Expected OUT values are queued as each program is started and popped
// whenever the core strobes out_valid.
module tb_trash_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        prog_we = 1'b0;
  logic [15:0] prog_data = '0;
  logic        start = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        halted;
  logic [3:0]  pc;

  trash_cpu #(
    .DATA_W    (8),
    .NUM_REGS  (4),
    .PROG_DEPTH(16),
    .MEM_DEPTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .prog_we  (prog_we),
    .prog_data(prog_data),
    .start    (start),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy),
    .halted   (halted),
    .pc       (pc)
  );

  bit clk_on = 1'b0;
  always #5 if (clk_on) clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_out = 0;
  int last_out_cyc = -1;
  logic [7:0] exp_q[$];

  // ALU results for d=0x0C,s=0x05 and d=0x81,s=0x83, indexed by function
  localparam logic [7:0] EXP_P0 [16] = '{8'h11, 8'h07, 8'h04, 8'h0D, 8'h09, 8'hFA, 8'h05, 8'h18,
                                        8'h06, 8'h0D, 8'h0B, 8'h3C, 8'h00, 8'h00, 8'h0C, 8'h0C};
  localparam logic [7:0] EXP_P1 [16] = '{8'h04, 8'hFE, 8'h81, 8'h83, 8'h02, 8'h7C, 8'h83, 8'h02,
                                        8'h40, 8'h82, 8'h80, 8'h03, 8'h00, 8'h01, 8'h81, 8'h81};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      n_out++;
      last_out_cyc = cyc;
      if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
      else check("out_spurious", out_valid, 1'b0);
    end
  endtask

  task automatic load(input logic [15:0] w);
    prog_we   = 1'b1;
    prog_data = w;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic go(output int s_cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_halt(input int budget, output int h_cyc);
    h_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (halted === 1'b1) begin
        h_cyc = cyc;
        break;
      end
    end
    check("halt_reached", halted, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, h, n0;
    logic [7:0] dv, sv;

    // Asynchronous reset with the clock stopped
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_pc", pc, 4'h0);
    #4 rst_n = 1'b1;
    clk_on = 1'b1;
    step();
    check("idle_busy", busy, 1'b0);
    check("idle_halted", halted, 1'b0);

    // All-NOP program: pc wraps 15 -> 0 without halting
    go(s);
    check("nop_busy", busy, 1'b1);
    check("nop_pc0", pc, 4'h0);
    repeat (15) step();
    check("nop_pc15", pc, 4'hF);
    step();
    check("nop_pc_wrap", pc, 4'h0);
    check("nop_still_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("nop_rst_busy", busy, 1'b0);
    #2 rst_n = 1'b1;
    step();
    check("nop_rst_idle", busy, 1'b0);

    // LDI/LDI/ADD/OUT/HALT with cycle timing
    load(16'h1005);
    load(16'h1103);
    load(16'h2001);
    load(16'h7000);
    load(16'h8000);
    exp_q.push_back(8'h08);
    n0 = n_out;
    go(s);
    wait_halt(20, h);
    check("add_out_count", n_out - n0, 1);
    check("add_out_cycle", last_out_cyc - s, 4);
    check("add_halt_cycle", h - s, 5);
    check("add_pc", pc, 4'h4);
    check("add_busy", busy, 1'b0);
    check("add_drained", exp_q.size(), 0);

    // Count-down loop with JZ/JMP
    load(16'h1003);
    load(16'h2A00);
    load(16'h6004);
    load(16'h5001);
    load(16'h7000);
    load(16'h8000);
    exp_q.push_back(8'h00);
    n0 = n_out;
    go(s);
    wait_halt(30, h);
    check("loop_out_count", n_out - n0, 1);
    check("loop_halt_cycle", h - s, 11);
    check("loop_pc", pc, 4'h5);
    check("loop_drained", exp_q.size(), 0);

    // Memory forwarding and address wrap (0x17 aliases 0x7)
    load(16'h12FF);
    load(16'h2920);
    load(16'h3207);
    load(16'h4307);
    load(16'h7300);
    load(16'h1142);
    load(16'h3117);
    load(16'h4307);
    load(16'h7300);
    load(16'h8000);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h42);
    go(s);
    wait_halt(30, h);
    check("mem_drained", exp_q.size(), 0);

    // Every ALU function for two operand pairs, four per program
    for (int p = 0; p < 2; p++) begin
      dv = (p == 0) ? 8'h0C : 8'h81;
      sv = (p == 0) ? 8'h05 : 8'h83;
      for (int g = 0; g < 4; g++) begin
        load({8'h11, dv});
        load({8'h12, sv});
        for (int k = 0; k < 4; k++) begin
          load(16'h2631);
          load({4'h2, 4'(g * 4 + k), 8'h32});
          load(16'h7300);
          exp_q.push_back((p == 0) ? EXP_P0[g * 4 + k] : EXP_P1[g * 4 + k]);
        end
        load(16'h8000);
        go(s);
        wait_halt(30, h);
        check("alu_drained", exp_q.size(), 0);
      end
    end

    // Equality true case and 0 - 1 wrap
    load(16'h1133);
    load(16'h2C11);
    load(16'h7100);
    load(16'h1000);
    load(16'h2A00);
    load(16'h7000);
    load(16'h8000);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    go(s);
    wait_halt(30, h);
    check("eqdec_drained", exp_q.size(), 0);

    // prog_we during RUN must not alter the program
    load(16'h1011);
    load(16'h7000);
    load(16'h8000);
    exp_q.push_back(8'h11);
    go(s);
    prog_we   = 1'b1;
    prog_data = 16'h8000;
    step();
    step();
    prog_we   = 1'b0;
    wait_halt(20, h);
    exp_q.push_back(8'h11);
    n0 = n_out;
    go(s);
    wait_halt(20, h);
    check("runwe_out_count", n_out - n0, 1);
    check("runwe_drained", exp_q.size(), 0);

    // start together with prog_we: new word executes at pc 0
    exp_q.push_back(8'h22);
    prog_we   = 1'b1;
    prog_data = 16'h1022;
    start     = 1'b1;
    step();
    prog_we   = 1'b0;
    start     = 1'b0;
    wait_halt(20, h);
    check("startwe_pc", pc, 4'h2);
    check("startwe_drained", exp_q.size(), 0);

    // Mid-run reset clears registers and returns to IDLE
    load(16'h125A);
    load(16'h5001);
    go(s);
    repeat (5) step();
    check("midrst_running", busy, 1'b1);
    check("midrst_spin_pc", pc, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_pc", pc, 4'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("midrst_idle_busy", busy, 1'b0);
    check("midrst_idle_halted", halted, 1'b0);
    check("midrst_idle_pc", pc, 4'h0);
    load(16'h7200);
    load(16'h8000);
    exp_q.push_back(8'h00);
    go(s);
    wait_halt(20, h);
    check("midrst_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trash_cpu.md
# trash_cpu

Parametrised single-issue 8-bit-class processor core for the trash tile: 16-bit instructions, configurable data width, register count, program depth and scratch-memory depth. Unlike its predecessor, it fetches from its own program store, has explicit load/run/halt control, a full ALU, conditional branching and a validated output strobe. It sits directly behind the top-level pin mapper, which drives the programming and start inputs and exposes `out_data` on the dedicated outputs.

## Interface
- `DATA_W`, 8: register/memory word width (≥8; immediates zero-extended)
- `NUM_REGS`, 4: register count, power of 2, 2..16
- `PROG_DEPTH`, 16: program words, power of 2, 2..256
- `MEM_DEPTH`, 16: scratch-memory words, power of 2, 2..256

- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `prog_we` in 1: write `prog_data` at load pointer (IDLE/HALTED only)
- `prog_data` in 16: instruction word
- `start` in 1: begin execution at pc 0 (IDLE/HALTED only)
- `out_data` out DATA_W: last value emitted by OUT
- `out_valid` out 1: one-cycle strobe per OUT
- `busy` out 1: state == RUN
- `halted` out 1: state == HALTED
- `pc` out log2(PROG_DEPTH): current program counter

## Operation
- States: IDLE (reset), RUN, HALTED. IDLE/HALTED --start--> RUN; RUN --HALT instr--> HALTED. No other transitions except reset.
- Loading: in IDLE/HALTED, `prog_we` writes prog[ldptr], ldptr += 1 mod PROG_DEPTH. ldptr clears to 0 on entry to RUN. `prog_we` in RUN ignored.
- `start` with `prog_we` same cycle: write commits at old ldptr, then RUN begins; pc0 fetch sees the written word.
- Entering RUN sets pc = 0. Registers and scratch memory persist across runs; only reset clears them.
- Instruction: [15:12] op, [11:8] A, [7:4] B, [3:0] C, [7:0] imm. Register index = field mod NUM_REGS; memory/jump address = imm mod depth.
- 0 NOP. 1 LDI: r[A] = imm. 2 ALU: r[B] = r[B] f(A) r[C]. 3 ST: mem[imm] = r[A]. 4 LD: r[A] = mem[imm]. 5 JMP: pc = imm. 6 JZ: if r[A]==0, pc = imm. 7 OUT: out_data = r[A], out_valid pulse. 8 HALT. 9–F treated as NOP.
- ALU f (dest B, src C): 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not src, 6 mov src, 7 shl dest 1, 8 shr dest 1 (logical), 9 inc dest, A dec dest, B mul low DATA_W bits, C eq (1/0), D ult (1/0), E/F pass dest unchanged.
- All arithmetic mod 2^DATA_W; 0xFF+1 = 0x00, 0x00-1 = 0xFF for DATA_W=8.
- Non-branching instrs: pc += 1 mod PROG_DEPTH (wraps, no halt on overflow).
- Reset program contents are all zero (NOP), so start after reset spins with pc wrapping.

## Timing
- Reset (asynchronous, immediate): state IDLE, pc 0, ldptr 0, all regs/mem/prog 0, `out_data` 0, `out_valid` 0, `busy` 0, `halted` 0.
- `start` sampled at edge N: `busy` = 1 after N; pc0 executes in cycle N+1.
- One instruction per cycle in RUN; no stalls or hazards — a result written at edge K is read by the instruction executing after K. ST then LD to same address on consecutive cycles returns stored value.
- OUT executed in cycle K: `out_data` updated and `out_valid` = 1 for cycle K+1 only; back-to-back OUTs give consecutive strobes.
- HALT executed in cycle K: `halted` = 1, `busy` = 0 from K+1; pc holds HALT's address.
- `start` in RUN ignored. Reset deasserting mid-run resumes in IDLE, never RUN.

## Test plan
- Reset: drive rst_n low with clk stopped -> all outputs 0 immediately; state IDLE.
- Load LDI r0,5; LDI r1,3; ALU add r0,r0,r1; OUT r0; HALT; start -> exactly one `out_valid` with `out_data`=0x08 at cycle start+5; `halted`=1, pc=4.
- Loop: LDI r0,3; ALU dec r0; JZ r0,4; JMP 1; OUT r0; HALT -> single OUT of 0x00, HALT reached 11 cycles after pc0 issue.
- Memory/wrap: LDI r2,0xFF; ALU inc r2; ST r2,[7]; LD r3,[7]; OUT r3 -> `out_data`=0x00; repeat with addr 0x17 (MEM_DEPTH=16) -> same location.
- Control edges: `prog_we` pulses during RUN -> program unchanged; `start`+`prog_we` same cycle -> written word executes at pc0; all-NOP program -> pc wraps 15→0.
- Mid-run reset: assert rst_n low during RUN -> `busy` 0 asynchronously, regs cleared; after release, `start` required to run.
